// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream FIFO and sends them as UART frames.
// Frame is start, D0..D7 (LSB first), optional even parity, stop; tx idles high.
// Ports:
//   clk, rst              clock, async active-high reset
//   fifo_empty, fifo_dout FIFO status and registered read data
//   fifo_rd_en            one-cycle registered read strobe
//   tx                    registered serial line
//   busy                  high whenever not idle
//   tx_done               one-cycle pulse after each stop bit
//   bytes_sent            completed frame count, wraps at 2^16
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic        tx_done,
    output logic [15:0] bytes_sent
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic          bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

    // tx is loaded one edge ahead of each bit so the line changes exactly
    // on bit boundaries; the shifter therefore feeds shift_reg[1] forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            fifo_rd_en <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            bytes_sent <= '0;
        end else begin
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
            unique case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (!fifo_empty) begin
                        state      <= FETCH;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shift_reg  <= fifo_dout;
                    parity_bit <= ^fifo_dout;
                    bit_idx    <= '0;
                    baud_cnt   <= '0;
                    tx         <= 1'b0;
                    state      <= START;
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt   <= '0;
                        busy       <= 1'b0;
                        tx_done    <= 1'b1;
                        bytes_sent <= bytes_sent + 16'd1;
                        state      <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two instances (8N1 and 8E1) fed by queue-based FIFO models.
// A frame-timeline model predicts every output on every cycle.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        fe0 = 1'b1;
    logic        fe1 = 1'b1;
    logic [7:0]  fd0 = 8'h00;
    logic [7:0]  fd1 = 8'h00;
    logic        rd0, tx0, busy0, done0;
    logic        rd1, tx1, busy1, done1;
    logic [15:0] bs0, bs1;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .fifo_empty(fe0), .fifo_dout(fd0),
        .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .tx_done(done0),
        .bytes_sent(bs0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .fifo_empty(fe1), .fifo_dout(fd1),
        .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .tx_done(done1),
        .bytes_sent(bs1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // FIFO models: registered data on the read edge, empty flag at negedge.
    logic [7:0] fq0[$];
    logic [7:0] fq1[$];

    initial forever begin
        @(posedge clk);
        if (rd0 && fq0.size() > 0) fd0 <= fq0.pop_front();
        if (rd1 && fq1.size() > 0) fd1 <= fq1.pop_front();
    end

    initial forever begin
        @(negedge clk);
        fe0 = (fq0.size() == 0);
        fe1 = (fq1.size() == 0);
    end

    // Reference model: a frame is a timeline t = 1..L after the accepting
    // edge. t=1 strobe, t=2 load, t=3.. serial bits, t=L idle with done.
    logic [7:0]  mq0[$];
    logic [7:0]  mq1[$];
    bit          act[2] = '{0, 0};
    int          t[2] = '{0, 0};
    int          len[2] = '{0, 0};
    logic [10:0] fbits[2];
    logic [15:0] mcnt[2] = '{16'd0, 16'd0};
    logic [15:0] off0 = 16'd0;

    function automatic logic [10:0] frame(logic [7:0] b, bit par);
        return {1'b1, par ? ^b : 1'b1, b, 1'b0};
    endfunction

    initial forever begin
        logic [7:0] b;
        @(posedge clk or posedge rst);
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                act[c]  = 0;
                t[c]    = 0;
                mcnt[c] = 16'd0;
            end else if (act[c] && t[c] < len[c]) begin
                t[c] = t[c] + 1;
                if (t[c] == len[c]) mcnt[c] = mcnt[c] + 16'd1;
            end else if ((c == 0) ? !fe0 : !fe1) begin
                b        = (c == 0) ? mq0.pop_front() : mq1.pop_front();
                act[c]   = 1;
                t[c]     = 1;
                len[c]   = 3 + ((c == 1) ? 11 : 10) * CPB;
                fbits[c] = frame(b, c == 1);
            end else begin
                act[c] = 0;
            end
        end
    end

    task automatic cmp(int c, logic r, logic x, logic b, logic d,
                       logic [15:0] n);
        logic ex;
        logic [15:0] en;
        int tt;
        tt = t[c];
        ex = (act[c] && tt >= 3 && tt < len[c]) ? fbits[c][(tt-3)/CPB] : 1'b1;
        en = mcnt[c] + ((c == 0) ? off0 : 16'd0);
        chk($sformatf("ch%0d_rd_en", c), r, act[c] && tt == 1);
        chk($sformatf("ch%0d_tx", c), x, ex);
        chk($sformatf("ch%0d_busy", c), b, act[c] && tt >= 1 && tt < len[c]);
        chk($sformatf("ch%0d_tx_done", c), d, act[c] && tt == len[c]);
        chk($sformatf("ch%0d_bytes_sent", c), n, en);
    endtask

    initial forever begin
        @(negedge clk);
        cmp(0, rd0, tx0, busy0, done0, bs0);
        cmp(1, rd1, tx1, busy1, done1, bs1);
    end

    // Capture buffer for literal, hand-computed checks.
    logic ltx[200];
    logic ldn[200];
    int   ncap, nrd, ndn, nbusy;

    task automatic push(int c, logic [7:0] b);
        @(negedge clk);
        #1;
        if (c == 0) begin fq0.push_back(b); mq0.push_back(b); end
        else begin fq1.push_back(b); mq1.push_back(b); end
    endtask

    task automatic cap(int c, int n);
        nrd = 0; ndn = 0; nbusy = 0; ncap = n;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ltx[i] = (c == 0) ? tx0 : tx1;
            ldn[i] = (c == 0) ? done0 : done1;
            if ((c == 0) ? rd0 : rd1) nrd++;
            if (ldn[i]) ndn++;
            if ((c == 0) ? busy0 : busy1) nbusy++;
        end
    endtask

    function automatic int find_lo(int from);
        for (int i = from; i < ncap; i++) if (ltx[i] == 1'b0) return i;
        return -1;
    endfunction

    function automatic int find_dn(int from);
        for (int i = from; i < ncap; i++) if (ldn[i]) return i;
        return -1;
    endfunction

    task automatic chk_pat(string nm, int f, logic [10:0] pat, int nb);
        chk({nm, "_start_seen"}, f >= 0 && f < 140, 1);
        if (f >= 0 && f < 140)
            for (int k = 0; k < nb; k++)
                chk($sformatf("%s_bit%0d", nm, k), ltx[f + k*CPB + 2], pat[k]);
    endtask

    task automatic do_reset();
        @(negedge clk); #1; rst = 1'b1;
        @(negedge clk); #1; rst = 1'b0;
    endtask

    initial begin
        int f, d, f2, d2;
        bit hit;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx0, 1);
        chk("rst_rd_en", rd0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_tx_done", done0, 0);
        chk("rst_bytes_sent", bs0, 0);
        #1 rst = 1'b0;

        // 0xA5, 8N1
        push(0, 8'hA5);
        cap(0, 60);
        f = find_lo(0); d = find_dn(0);
        chk("a5_rd_pulses", nrd, 1);
        chk("a5_done_pulses", ndn, 1);
        chk("a5_frame_len", d - f, 10*CPB);
        chk("a5_bytes_sent", bs0, 1);
        chk_pat("a5", f, 11'b00_1101001010, 10);

        // 0x3C then 0x81 back to back
        do_reset();
        push(0, 8'h3C);
        fq0.push_back(8'h81); mq0.push_back(8'h81);
        cap(0, 100);
        f = find_lo(0); d = find_dn(0);
        f2 = (d >= 0) ? find_lo(d) : -1;
        d2 = (d >= 0) ? find_dn(d + 1) : -1;
        chk("b2b_rd_pulses", nrd, 2);
        chk("b2b_done_pulses", ndn, 2);
        chk("b2b_gap", f2 - d, 3);
        chk("b2b_len2", d2 - f2, 10*CPB);
        chk("b2b_bytes_sent", bs0, 2);
        chk_pat("b2b_3c", f, 11'b00_1001111000, 10);
        chk_pat("b2b_81", f2, 11'b00_1100000010, 10);

        // empty FIFO for 100 cycles
        do_reset();
        cap(0, 100);
        chk("idle_rd_pulses", nrd, 0);
        chk("idle_busy_cycles", nbusy, 0);
        chk("idle_tx_low", find_lo(0), 32'hFFFF_FFFF);

        // 8E1: 0x07 has parity 1, 0x03 has parity 0
        push(1, 8'h07);
        cap(1, 60);
        f = find_lo(0); d = find_dn(0);
        chk("p07_frame_len", d - f, 11*CPB);
        chk("p07_bytes_sent", bs1, 1);
        chk_pat("p07", f, 11'b11000001110, 11);
        push(1, 8'h03);
        cap(1, 60);
        f = find_lo(0); d = find_dn(0);
        chk("p03_frame_len", d - f, 11*CPB);
        chk("p03_bytes_sent", bs1, 2);
        chk_pat("p03", f, 11'b10000000110, 11);

        // reset during data bit 3
        push(0, 8'h5A);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (act[0] && t[0] == 3 + 4*CPB + 1) hit = 1;
        end
        chk("mid_reset_reached", hit, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_reset_tx", tx0, 1);
        chk("mid_reset_busy", busy0, 0);
        push(0, 8'hC3);
        @(negedge clk); #1 rst = 1'b0;
        cap(0, 60);
        f = find_lo(0);
        chk("after_rst_rd_pulses", nrd, 1);
        chk("after_rst_bytes_sent", bs0, 1);
        chk_pat("after_rst_c3", f, 11'b00_1110000110, 10);

        // counter wrap
        do_reset();
        @(negedge clk); #1;
        force dut0.bytes_sent = 16'hFFFF;
        off0 = 16'hFFFF;
        @(negedge clk); #1;
        release dut0.bytes_sent;
        push(0, 8'h55);
        cap(0, 60);
        chk("wrap_done_pulses", ndn, 1);
        chk("wrap_bytes_sent", bs0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
